// File: rtl/fir_pkg.sv
// Shared types, helpers and reference coefficient sets for the TDM FIR filter.
package fir_pkg;

  // Controller states: wait for a sample, run the taps, publish the result.
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Accumulator width that holds N full-precision products without overflow.
  function automatic int acc_width(input int w, input int h, input int n);
    return w + h + $clog2(n);
  endfunction

  // Symmetric low-pass, DC gain 256 (unity after an 8-bit shift).
  // The centre taps (157) need a coefficient width of at least 9 bits.
  localparam int LOWPASS8 [8] = '{-2, 8, -35, 157, 157, -35, 8, -2};

endpackage

// File: rtl/fir_coef_bank.sv
// Run-time loadable N x H coefficient register file: synchronous write,
// combinational read for the shared MAC.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int H = 8,
  parameter int N = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [H-1:0]         wr_data,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic signed [H-1:0]  rd_data
);

  localparam int AW = $clog2(N);

  logic signed [H-1:0] coef_word [N];

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_coef
    logic signed [H-1:0] coef_reg;

    // One coefficient: cleared on reset, loaded when its address is written.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        coef_reg <= '0;
      end else if (we && (wr_addr == AW'(gi))) begin
        coef_reg <= wr_data;
      end
    end

    assign coef_word[gi] = coef_reg;
  end

  assign rd_data = coef_word[rd_addr];

endmodule

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over N taps,
// then round, saturate and publish. One sample per N+2 cycles.
module fir_tdm_filter
  import fir_pkg::*;
#(
  parameter int W     = 32,
  parameter int H     = 8,
  parameter int N     = 8,
  parameter int SHIFT = 8,
  parameter int ROUND = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [W-1:0]         x_in,
  input  logic                 x_in_valid,
  output logic                 x_in_ready,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [H-1:0]         coef_data,
  output logic                 coef_err,
  output logic [W-1:0]         y_out,
  output logic                 y_out_valid,
  output logic                 y_sat
);

  localparam int AW   = $clog2(N);
  localparam int PW   = W + H;
  localparam int ACCW = acc_width(W, H, N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW:0]   NV   = (AW + 1)'(N);
  // Half an output LSB, added before the shift when rounding is enabled.
  localparam logic signed [ACCW:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((ACCW + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

  state_t                 state_reg;
  logic [AW-1:0]          k_reg;
  logic [AW-1:0]          wr_ptr_reg;
  logic signed [ACCW-1:0] acc_reg;
  logic [W-1:0]           y_out_reg;
  logic                   y_out_valid_reg;
  logic                   y_sat_reg;
  logic                   coef_err_reg;

  logic                   accept;
  logic                   coef_ok;
  logic [AW-1:0]          rd_idx;
  logic signed [H-1:0]    coef_rd;
  logic signed [W-1:0]    tap;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   shifted;
  logic [ACCW-W+1:0]      hi_bits;
  logic [W-1:0]           y_next;
  logic                   y_sat_next;
  logic signed [W-1:0]    delay_word [N];

  assign accept     = (state_reg == IDLE) && x_in_valid;
  // Writes land only while idle and in range, so a running sample never sees a mixed bank.
  assign coef_ok    = coef_we && (state_reg == IDLE) && (coef_addr <= LAST);
  assign x_in_ready = (state_reg == IDLE);

  fir_coef_bank #(.H(H), .N(N)) u_coef_bank (
    .clock   (clock),
    .reset   (reset),
    .we      (coef_ok),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_addr (k_reg),
    .rd_data (coef_rd)
  );

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_delay
    logic signed [W-1:0] tap_reg;

    // Circular delay-line slot: captures the accepted sample when the write pointer is here.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tap_reg <= '0;
      end else if (accept && (wr_ptr_reg == AW'(gi))) begin
        tap_reg <= x_in;
      end
    end

    assign delay_word[gi] = tap_reg;
  end

  // Tap k reads the sample k steps older than the newest: (wr_ptr - k) mod N.
  always_comb begin
    if (wr_ptr_reg >= k_reg) begin
      rd_idx = wr_ptr_reg - k_reg;
    end else begin
      rd_idx = AW'({1'b0, wr_ptr_reg} + NV - {1'b0, k_reg});
    end
  end

  assign tap      = delay_word[rd_idx];
  assign prod     = PW'(coef_rd) * PW'(tap);
  assign acc_next = acc_reg + ACCW'(prod);

  // Round, arithmetic shift, then clip anything that does not fit in W signed bits.
  always_comb begin
    rnd        = (ACCW + 1)'(acc_reg) + RND;
    shifted    = rnd >>> SHIFT;
    hi_bits    = shifted[ACCW:W-1];
    y_sat_next = !((&hi_bits) || !(|hi_bits));
    if (y_sat_next) begin
      y_next = shifted[ACCW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y_next = shifted[W-1:0];
    end
  end

  // Controller: accept, run N MAC cycles, publish result and advance the write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      wr_ptr_reg      <= '0;
      acc_reg         <= '0;
      y_out_reg       <= '0;
      y_out_valid_reg <= 1'b0;
      y_sat_reg       <= 1'b0;
      coef_err_reg    <= 1'b0;
    end else begin
      y_out_valid_reg <= 1'b0;
      coef_err_reg    <= coef_we && !coef_ok;
      case (state_reg)
        IDLE: begin
          if (x_in_valid) begin
            acc_reg   <= '0;
            k_reg     <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          if (k_reg == LAST) begin
            state_reg <= OUT;
          end else begin
            k_reg <= k_reg + AW'(1);
          end
        end
        OUT: begin
          y_out_reg       <= y_next;
          y_sat_reg       <= y_sat_next;
          y_out_valid_reg <= 1'b1;
          wr_ptr_reg      <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + AW'(1);
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y_out       = y_out_reg;
  assign y_out_valid = y_out_valid_reg;
  assign y_sat       = y_sat_reg;
  assign coef_err    = coef_err_reg;

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Bench for fir_tdm_filter: an 8-tap rounding instance and a 5-tap truncating
// instance, each checked against an integer FIR model through a scoreboard.
module tb_fir_tdm_filter;
  import fir_pkg::*;

  localparam int W  = 32;
  localparam int H  = 9;
  localparam int SH = 8;
  localparam int N0 = 8;
  localparam int N1 = 5;
  localparam longint YMAX = 64'sd2147483647;
  localparam longint YMIN = -64'sd2147483648;

  typedef struct {
    longint y;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [W-1:0] x0 = '0, x1 = '0;
  logic         xv0 = 1'b0, xv1 = 1'b0;
  logic         we0 = 1'b0, we1 = 1'b0;
  logic [2:0]   ca0 = '0, ca1 = '0;
  logic [H-1:0] cd0 = '0, cd1 = '0;
  logic         rdy0, rdy1, err0, err1, yv0, yv1, ys0, ys1;
  logic [W-1:0] y0, y1;

  fir_tdm_filter #(.W(W), .H(H), .N(N0), .SHIFT(SH), .ROUND(1)) dut0 (
    .clock(clock), .reset(reset), .x_in(x0), .x_in_valid(xv0), .x_in_ready(rdy0),
    .coef_we(we0), .coef_addr(ca0), .coef_data(cd0), .coef_err(err0),
    .y_out(y0), .y_out_valid(yv0), .y_sat(ys0)
  );

  fir_tdm_filter #(.W(W), .H(H), .N(N1), .SHIFT(SH), .ROUND(0)) dut1 (
    .clock(clock), .reset(reset), .x_in(x1), .x_in_valid(xv1), .x_in_ready(rdy1),
    .coef_we(we1), .coef_addr(ca1), .coef_data(cd1), .coef_err(err1),
    .y_out(y1), .y_out_valid(yv1), .y_sat(ys1)
  );

  exp_t   q0[$], q1[$];
  longint coefm [2][8];
  longint hist  [2][8];
  int     vectors = 0, miscompares = 0;
  int     cyc = 0;
  bit     pv0 = 1'b0, pv1 = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic errf(input int s);
    return (s == 0) ? err0 : err1;
  endfunction

  function automatic int ntaps(input int s);
    return (s == 0) ? N0 : N1;
  endfunction

  task automatic drive(input int s, input bit xv, input longint x, input bit we,
                       input int addr, input int data);
    if (s == 0) begin
      xv0 = xv; x0 = W'(x); we0 = we; ca0 = 3'(addr); cd0 = H'(data);
    end else begin
      xv1 = xv; x1 = W'(x); we1 = we; ca1 = 3'(addr); cd1 = H'(data);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 8; k++) begin
        coefm[s][k] = 0;
        hist[s][k]  = 0;
      end
  endtask

  // Shift-register FIR, full precision, then round (instance 0 only) and clip.
  task automatic model(input int s, input longint x, output longint y, output bit sat);
    longint acc = 0;
    for (int k = ntaps(s) - 1; k > 0; k--) hist[s][k] = hist[s][k-1];
    hist[s][0] = x;
    for (int k = 0; k < ntaps(s); k++) acc += coefm[s][k] * hist[s][k];
    if (s == 0) acc += 128;
    y   = acc >>> SH;
    sat = 1'b0;
    if (y > YMAX) begin y = YMAX; sat = 1'b1; end
    else if (y < YMIN) begin y = YMIN; sat = 1'b1; end
  endtask

  task automatic wait_ready(input int s, output bit ok);
    int t = 0;
    @(negedge clock);
    while (!rdy(s) && t < 60) begin
      @(negedge clock);
      t++;
    end
    ok = rdy(s);
    if (!ok) check($sformatf("ready_timeout%0d", s), 0, 1);
  endtask

  // Offer one sample (optionally with a same-cycle coefficient write) and log the expectation.
  task automatic send(input int s, input longint x, input bit push = 1'b1,
                      input bit we = 1'b0, input int addr = 0, input int data = 0);
    bit ok;
    exp_t e;
    wait_ready(s, ok);
    if (!ok) return;
    drive(s, 1'b1, x, we, addr, data);
    if (we) coefm[s][addr] = data;
    if (push) begin
      model(s, x, e.y, e.sat);
      e.cyc = cyc;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clock);
    #1 drive(s, 1'b0, 0, 1'b0, 0, 0);
    if (we) check($sformatf("err_on_accept%0d", s), errf(s), 0);
  endtask

  task automatic coef_wr(input int s, input int addr, input int data);
    bit ok;
    @(negedge clock);
    ok = rdy(s) && (addr < ntaps(s));
    drive(s, 1'b0, 0, 1'b1, addr, data);
    if (ok) coefm[s][addr] = data;
    @(posedge clock);
    #1 drive(s, 1'b0, 0, 1'b0, 0, 0);
    check($sformatf("coef_err%0d_a%0d", s, addr), errf(s), !ok);
  endtask

  // Present a sample while busy; it must be refused and never produce an output.
  task automatic poke_busy(input int s, input longint x);
    @(negedge clock);
    check($sformatf("ready_busy%0d", s), rdy(s), 0);
    drive(s, 1'b1, x, 1'b0, 0, 0);
    @(posedge clock);
    #1 drive(s, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
  endtask

  task automatic got_out(input int s, input longint y, input bit sat);
    exp_t e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      check($sformatf("spurious_out%0d", s), 1, 0);
      return;
    end
    if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
    $display("dut%0d out y=%0d sat=%0d (exp %0d/%0d)", s, y, sat, e.y, e.sat);
    check($sformatf("y%0d", s), y, e.y);
    check($sformatf("sat%0d", s), sat, e.sat);
    check($sformatf("latency%0d", s), cyc - e.cyc, ntaps(s) + 2);
  endtask

  // Output monitor: scoreboard compare plus one-cycle valid width.
  always @(negedge clock) begin
    if (pv0) check("vwidth0", yv0, 0);
    if (pv1) check("vwidth1", yv1, 0);
    if (yv0) got_out(0, longint'($signed(y0)), ys0);
    if (yv1) got_out(1, longint'($signed(y1)), ys1);
    pv0 <= yv0;
    pv1 <= yv1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(negedge clock);
    check("rst_ready", rdy0, 1);
    check("rst_y", y0, 0);
    check("rst_valid", yv0, 0);
    check("rst_sat", ys0, 0);
    check("rst_err", err0, 0);
    check("rst_ready1", rdy1, 1);
    reset = 1'b0;

    // Impulse response of the low-pass set.
    for (int k = 0; k < 8; k++) coef_wr(0, k, LOWPASS8[k]);
    send(0, 256);
    repeat (7) send(0, 0);

    // DC gain: settles to the input value.
    repeat (12) send(0, 1000);

    // Full-scale inputs with large coefficients clip both ways.
    for (int k = 0; k < 8; k++) coef_wr(0, k, 127);
    repeat (10) send(0, YMAX);
    repeat (10) send(0, YMIN);

    // Round-half-up at the shift boundary.
    for (int k = 0; k < 8; k++) coef_wr(0, k, (k == 0) ? 1 : 0);
    send(0, 128); send(0, -128); send(0, 127); send(0, -129); send(0, 384);

    // Writes and samples while busy are dropped; the response is unchanged.
    for (int k = 0; k < 8; k++) coef_wr(0, k, LOWPASS8[k]);
    send(0, 256);
    coef_wr(0, 3, 55);
    poke_busy(0, 12345);
    repeat (7) send(0, 0);

    // Random samples and coefficients, including a write on the accept cycle.
    for (int k = 0; k < 8; k++) coef_wr(0, k, int'($urandom_range(0, 511)) - 256);
    for (int i = 0; i < 12; i++) send(0, longint'($signed($urandom)));
    send(0, 777, 1'b1, 1'b1, 5, -200);
    send(0, -4321);

    // Truncating 5-tap instance: rounding off, out-of-range address, pointer wrap.
    coef_wr(1, 0, 1);
    send(1, 128); send(1, -128); send(1, 255); send(1, 256); send(1, -1);
    coef_wr(1, 5, 77);
    coef_wr(1, 7, -5);
    for (int k = 0; k < 5; k++) coef_wr(1, k, int'($urandom_range(0, 511)) - 256);
    for (int i = 0; i < 13; i++) send(1, longint'($signed($urandom)) >>> ($urandom_range(0, 20)));
    send(1, 99, 1'b1, 1'b1, 2, -100);
    send(1, 5000);
    drain();

    // Reset during MAC aborts the sample and clears coefficients and history.
    send(0, 5, 1'b0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    clear_model();
    @(negedge clock);
    check("abort_ready", rdy0, 1);
    check("abort_y", y0, 0);
    check("abort_sat", ys0, 0);
    check("abort_valid", yv0, 0);
    reset = 1'b0;
    send(0, 256);
    repeat (7) send(0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
